vga_scan: RTL and testbench

VGA_SCAN -- requirements
Module: vga_scan

---
 rtl/vga_scan_if.sv | 35 +++
 rtl/vga_scan.sv | 108 ++++++++++
 tb/tb_vga_scan.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_if.sv
`default_nettype none
// ============================================================================
// vga_scan_if : scan-address / pixel / video bundle between vga_scan and renderers
// Revision 1.0 - initial release
// ============================================================================
interface vga_scan_if;
  logic        pixel_in;
  logic        blank;
  logic [11:0] fg_color;
  logic [11:0] bg_color;
  logic [9:0]  haddress;
  logic [9:0]  vaddress;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        frame_tick;

  // Timing generator side
  modport master (
    input  pixel_in, blank, fg_color, bg_color,
    output haddress, vaddress, pix_en, hsync, vsync,
           red, green, blue, frame_tick
  );

  // Renderer / display side
  modport slave (
    output pixel_in, blank, fg_color, bg_color,
    input  haddress, vaddress, pix_en, hsync, vsync,
           red, green, blue, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/vga_scan.sv
`default_nettype none
// ============================================================================
// vga_scan : VGA raster scan timing generator with registered RGB444 output stage
// Revision 1.0 - initial release
// ============================================================================
module vga_scan #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  wire logic  clk,
  input  wire logic  reset,
  vga_scan_if.master bus
);

  localparam int unsigned c_H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned c_V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [3:0]  c_DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);
  localparam logic [9:0]  c_H_VIS    = 10'(H_VIS);
  localparam logic [9:0]  c_V_VIS    = 10'(V_VIS);
  localparam logic [9:0]  c_HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0]  c_HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  c_VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0]  c_VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [3:0]  r_div;
  logic [9:0]  r_haddr;
  logic [9:0]  r_vaddr;
  logic [11:0] r_rgb;
  logic        r_hsync;
  logic        r_vsync;

  logic        w_pix_en;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_active;
  logic        w_hs_zone;
  logic        w_vs_zone;
  logic [11:0] w_color;

  assign w_pix_en  = (r_div == c_DIV_LAST);
  assign w_h_last  = (r_haddr == c_H_LAST);
  assign w_v_last  = (r_vaddr == c_V_LAST);
  assign w_active  = (r_haddr < c_H_VIS) && (r_vaddr < c_V_VIS);
  assign w_hs_zone = (r_haddr >= c_HS_BEG) && (r_haddr < c_HS_END);
  assign w_vs_zone = (r_vaddr >= c_VS_BEG) && (r_vaddr < c_VS_END);

  // Decoded from the slot being closed; pixel_in is settled by the closing pix_en.
  assign w_color = (!w_active || bus.blank) ? 12'h000
                 : (bus.pixel_in ? bus.fg_color : bus.bg_color);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= 4'd0;
    end else if (w_pix_en) begin
      r_div <= 4'd0;
    end else begin
      r_div <= r_div + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_haddr <= 10'd0;
      r_vaddr <= 10'd0;
    end else if (w_pix_en) begin
      if (w_h_last) begin
        r_haddr <= 10'd0;
        r_vaddr <= w_v_last ? 10'd0 : r_vaddr + 10'd1;
      end else begin
        r_haddr <= r_haddr + 10'd1;
      end
    end
  end

  // Video and sync share one register stage so they stay aligned, one slot behind the address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb   <= 12'h000;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_pix_en) begin
      r_rgb   <= w_color;
      r_hsync <= !w_hs_zone;
      r_vsync <= !w_vs_zone;
    end
  end

  assign bus.haddress   = r_haddr;
  assign bus.vaddress   = r_vaddr;
  assign bus.pix_en     = w_pix_en;
  assign bus.frame_tick = w_pix_en & w_h_last & w_v_last;
  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.red        = r_rgb[11:8];
  assign bus.green      = r_rgb[7:4];
  assign bus.blue       = r_rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_scan.sv
`default_nettype none
// ============================================================================
// tb_vga_scan : randomized bench for vga_scan against a slot-index raster model
// Revision 1.0 - initial release
// ============================================================================
module tb_vga_scan;
  localparam int CLK_DIV = 4;
  localparam int H_VIS = 20, H_FP = 3, H_SYNC = 5, H_BP = 4;
  localparam int V_VIS = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;

  logic clk = 1'b0;
  logic reset;

  vga_scan_if vif ();

  vga_scan #(
    .CLK_DIV(CLK_DIV),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (vif)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Model state: edges since reset release, and the output pending from the last closed slot
  int          e;
  bit          have_out;
  logic [11:0] exp_col;
  logic        exp_hs, exp_vs;
  int          mode;
  bit          measure;
  int          pe_cnt, tick_cnt, hs_low, vs_low;
  int          last_tick_e;

  task automatic check_reset(input string tag);
    check({tag, "_pix_en"},     32'(vif.pix_en),     32'd0);
    check({tag, "_frame_tick"}, 32'(vif.frame_tick), 32'd0);
    check({tag, "_haddress"},   32'(vif.haddress),   32'd0);
    check({tag, "_vaddress"},   32'(vif.vaddress),   32'd0);
    check({tag, "_hsync"},      32'(vif.hsync),      32'd1);
    check({tag, "_vsync"},      32'(vif.vsync),      32'd1);
    check({tag, "_rgb"},        32'({vif.red, vif.green, vif.blue}), 32'd0);
  endtask

  task automatic check_now();
    int  s, h, v;
    bit  pe, ft;
    logic [11:0] col;
    s  = e / CLK_DIV;
    h  = s % HT;
    v  = (s / HT) % VT;
    pe = ((e + 1) % CLK_DIV) == 0;
    ft = pe && (h == HT - 1) && (v == VT - 1);
    col = have_out ? exp_col : 12'h000;
    check("pix_en",     32'(vif.pix_en),     32'(pe));
    check("frame_tick", 32'(vif.frame_tick), 32'(ft));
    check("haddress",   32'(vif.haddress),   32'(h));
    check("vaddress",   32'(vif.vaddress),   32'(v));
    check("red",        32'(vif.red),        32'(col[11:8]));
    check("green",      32'(vif.green),      32'(col[7:4]));
    check("blue",       32'(vif.blue),       32'(col[3:0]));
    check("hsync",      32'(vif.hsync),      32'(have_out ? exp_hs : 1'b1));
    check("vsync",      32'(vif.vsync),      32'(have_out ? exp_vs : 1'b1));
    if (vif.frame_tick === 1'b1) begin
      if (last_tick_e >= 0) check("tick_period", 32'(e - last_tick_e), 32'(FRAME_CLKS));
      last_tick_e = e;
    end
    if (measure) begin
      if (e < FRAME_CLKS && vif.pix_en === 1'b1)     pe_cnt++;
      if (e < FRAME_CLKS && vif.frame_tick === 1'b1) tick_cnt++;
      // Output slots reflecting closed slots 0..HT*VT-1, i.e. exactly one frame
      if (e > 0 && (e % CLK_DIV) == 0 && (e / CLK_DIV) <= HT * VT) begin
        if (vif.hsync === 1'b0) hs_low++;
        if (vif.vsync === 1'b0) vs_low++;
      end
    end
  endtask

  task automatic drive_and_predict();
    int s, h, v;
    bit act;
    case (mode)
      1: begin
        vif.pixel_in = 1'b1;  vif.blank = 1'b0;
        vif.fg_color = 12'hF00; vif.bg_color = 12'h00F;
      end
      2: begin
        vif.pixel_in = 1'b1;  vif.blank = 1'b1;
        vif.fg_color = 12'($urandom); vif.bg_color = 12'($urandom);
      end
      default: begin
        vif.pixel_in = 1'($urandom_range(0, 1));
        vif.blank    = ($urandom_range(0, 7) == 0);
        vif.fg_color = 12'($urandom);
        vif.bg_color = 12'($urandom);
      end
    endcase
    if (((e + 1) % CLK_DIV) == 0) begin
      s   = e / CLK_DIV;
      h   = s % HT;
      v   = (s / HT) % VT;
      act = (h < H_VIS) && (v < V_VIS);
      exp_col = (!act || vif.blank) ? 12'h000 : (vif.pixel_in ? vif.fg_color : vif.bg_color);
      exp_hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
      exp_vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
    end
  endtask

  task automatic run_cycles(input int n);
    bit closing;
    for (int i = 0; i < n; i++) begin
      check_now();
      drive_and_predict();
      closing = ((e + 1) % CLK_DIV) == 0;
      @(posedge clk);
      e++;
      if (closing) have_out = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic restart_model();
    e = 0;
    have_out = 1'b0;
    last_tick_e = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  s;
    bit  found;
    reset = 1'b0;
    vif.pixel_in = 1'b0; vif.blank = 1'b0;
    vif.fg_color = 12'h000; vif.bg_color = 12'h000;
    mode = 0; measure = 1'b0;
    pe_cnt = 0; tick_cnt = 0; hs_low = 0; vs_low = 0;
    restart_model();

    repeat (3) @(negedge clk);
    check_reset("por");

    // Release at a negedge: the next rising edge is edge 1
    reset = 1'b1;
    measure = 1'b1;
    mode = 0; run_cycles(FRAME_CLKS);
    measure = 1'b0;
    check("pix_en_per_frame", 32'(pe_cnt),   32'(HT * VT));
    check("ticks_per_frame",  32'(tick_cnt), 32'd1);
    check("hsync_low_slots",  32'(hs_low),   32'(H_SYNC * VT));
    check("vsync_low_slots",  32'(vs_low),   32'(V_SYNC * HT));
    mode = 1; run_cycles(HT * 8 * CLK_DIV);
    mode = 2; run_cycles(HT * 6 * CLK_DIV);
    mode = 0; run_cycles(FRAME_CLKS);

    // Walk to the middle of the raster, one clock into a slot
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      s = e / CLK_DIV;
      if ((s % HT) == HT / 2 && ((s / HT) % VT) == VT / 2 && (e % CLK_DIV) == 1) found = 1'b1;
      else run_cycles(1);
    end
    check("midframe_reached", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset("async_rst");
    restart_model();
    repeat (3) begin
      @(negedge clk);
      check_reset("held_rst");
    end
    reset = 1'b1;
    mode = 0; run_cycles(FRAME_CLKS + 64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
